// File: rtl/calendar_pkg.sv
// Shared types, reset constants and month-length helper for the calendar
// date blocks (date counter today, alarm-date block later).
package calendar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WAIT  = 2'd2
    } load_state_e;

    localparam logic [4:0] RST_DAY   = 5'd1;
    localparam logic [3:0] RST_MONTH = 4'd1;
    localparam logic [6:0] RST_YEAR  = 7'd0;
    localparam logic [2:0] RST_WDAY  = 3'd6;

    localparam logic [5:0] LAST_HOUR = 6'd23;
    localparam logic [5:0] LAST_MIN  = 6'd59;
    localparam logic [5:0] LAST_SEC  = 6'd59;
    localparam logic [6:0] LAST_YEAR = 7'd99;
    localparam logic [2:0] LAST_WDAY = 3'd6;

    // Year is an offset from 2000, so Year[1:0]==0 marks a leap year across
    // the whole 2000..2099 range (2000 itself is divisible by 400).
    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic [6:0] year);
        logic [4:0] days;
        case (month)
            4'd2:                      days = (year[1:0] == 2'd0) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   days = 5'd30;
            default:                   days = 5'd31;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/calendar_date_if.sv
// Date-load request/acknowledge bundle between a requester and the calendar.
interface calendar_date_if;

    logic       SetReq;
    logic [4:0] SetDay;
    logic [3:0] SetMonth;
    logic [6:0] SetYear;
    logic [2:0] SetWday;
    logic       SetAck;
    logic       SetErr;

    modport master (
        output SetReq, SetDay, SetMonth, SetYear, SetWday,
        input  SetAck, SetErr
    );

    modport slave (
        input  SetReq, SetDay, SetMonth, SetYear, SetWday,
        output SetAck, SetErr
    );

endinterface

// File: rtl/calendar_date_check.sv
// Combinational legality check of a candidate date; shared with the
// alarm-date block.
module calendar_date_check
    import calendar_pkg::*;
(
    input  logic [4:0] day_i,
    input  logic [3:0] month_i,
    input  logic [6:0] year_i,
    input  logic [2:0] wday_i,
    output logic       valid_o
);

    logic month_ok;
    logic day_ok;
    logic year_ok;
    logic wday_ok;

    assign month_ok = (month_i >= 4'd1) && (month_i <= 4'd12);
    // Out-of-range months fall to 31 in days_in_month; month_ok masks them.
    assign day_ok   = (day_i >= 5'd1) && (day_i <= days_in_month(month_i, year_i));
    assign year_ok  = (year_i <= LAST_YEAR);
    assign wday_ok  = (wday_i <= LAST_WDAY);

    assign valid_o = month_ok && day_ok && year_ok && wday_ok;

endmodule

// File: rtl/calendar_date.sv
// Day/month/year/weekday counter advanced by the 23:59:59 time-of-day wrap,
// with a validated request/acknowledge load port.
module calendar_date
    import calendar_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [5:0]            Hours,
    input  logic [5:0]            Mins,
    input  logic [5:0]            Secs,
    calendar_date_if.slave        set_if,
    output logic [4:0]            Day,
    output logic [3:0]            Month,
    output logic [6:0]            Year,
    output logic [2:0]            Wday,
    output logic                  NewDay
);

    load_state_e state_q, state_d;

    logic [4:0] day_q,   day_d;
    logic [3:0] month_q, month_d;
    logic [6:0] year_q,  year_d;
    logic [2:0] wday_q,  wday_d;
    logic       new_day_q, new_day_d;
    logic       ack_q,   ack_d;
    logic       err_q,   err_d;

    logic [4:0] sh_day_q;
    logic [3:0] sh_month_q;
    logic [6:0] sh_year_q;
    logic [2:0] sh_wday_q;

    logic       rollover;
    logic       capture_en;
    logic       in_check;
    logic       load_en;
    logic       shadow_valid;

    logic [4:0] adv_day;
    logic [3:0] adv_month;
    logic [6:0] adv_year;
    logic [2:0] adv_wday;

    assign rollover = (Hours == LAST_HOUR) && (Mins == LAST_MIN) && (Secs == LAST_SEC);

    calendar_date_check u_check (
        .day_i   (sh_day_q),
        .month_i (sh_month_q),
        .year_i  (sh_year_q),
        .wday_i  (sh_wday_q),
        .valid_o (shadow_valid)
    );

    // ---------------------------------------------------------------- FSM
    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values, whatever order the blocks run in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (set_if.SetReq) state_d = CHECK;
            CHECK:   state_d = WAIT;
            WAIT:    if (!set_if.SetReq) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture_en = (state_q == IDLE) && set_if.SetReq;
        in_check   = (state_q == CHECK);
        load_en    = in_check && shadow_valid;
        ack_d      = in_check;
        err_d      = in_check && !shadow_valid;
    end

    // -------------------------------------------------------- shadow regs
    // NOTE: the shadow registers are ordinary flops, not a memory, so they take
    // the async reset like everything else and never read back as X.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sh_day_q   <= '0;
            sh_month_q <= '0;
            sh_year_q  <= '0;
            sh_wday_q  <= '0;
        end else if (capture_en) begin
            sh_day_q   <= set_if.SetDay;
            sh_month_q <= set_if.SetMonth;
            sh_year_q  <= set_if.SetYear;
            sh_wday_q  <= set_if.SetWday;
        end
    end

    // ------------------------------------------------------ rollover step
    always_comb begin
        adv_day   = day_q + 5'd1;
        adv_month = month_q;
        adv_year  = year_q;
        if (day_q == days_in_month(month_q, year_q)) begin
            adv_day = 5'd1;
            if (month_q == 4'd12) begin
                adv_month = 4'd1;
                adv_year  = (year_q == LAST_YEAR) ? 7'd0 : year_q + 7'd1;
            end else begin
                adv_month = month_q + 4'd1;
            end
        end
        // Weekday runs free; it is not realigned on the 2099 -> 2000 wrap.
        adv_wday = (wday_q == LAST_WDAY) ? 3'd0 : wday_q + 3'd1;
    end

    // A valid load in the CHECK cycle takes priority and swallows a rollover.
    always_comb begin
        day_d     = day_q;
        month_d   = month_q;
        year_d    = year_q;
        wday_d    = wday_q;
        new_day_d = 1'b0;
        if (load_en) begin
            day_d   = sh_day_q;
            month_d = sh_month_q;
            year_d  = sh_year_q;
            wday_d  = sh_wday_q;
        end else if (rollover) begin
            day_d     = adv_day;
            month_d   = adv_month;
            year_d    = adv_year;
            wday_d    = adv_wday;
            new_day_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            day_q     <= RST_DAY;
            month_q   <= RST_MONTH;
            year_q    <= RST_YEAR;
            wday_q    <= RST_WDAY;
            new_day_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            day_q     <= day_d;
            month_q   <= month_d;
            year_q    <= year_d;
            wday_q    <= wday_d;
            new_day_q <= new_day_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign Day           = day_q;
    assign Month         = month_q;
    assign Year          = year_q;
    assign Wday          = wday_q;
    assign NewDay        = new_day_q;
    assign set_if.SetAck = ack_q;
    assign set_if.SetErr = err_q;

endmodule

// File: tb/tb_calendar_date.sv
// Directed bench for calendar_date: rollovers, month/year/century boundaries,
// load validation, load/rollover collisions, reset mid-handshake.
module tb_calendar_date;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Hours, Mins, Secs;
    logic [4:0] Day;
    logic [3:0] Month;
    logic [6:0] Year;
    logic [2:0] Wday;
    logic       NewDay;

    int n_cmp  = 0;
    int n_fail = 0;

    calendar_date_if set_if ();

    calendar_date dut (
        .CLK    (CLK),
        .RST    (RST),
        .Hours  (Hours),
        .Mins   (Mins),
        .Secs   (Secs),
        .set_if (set_if.slave),
        .Day    (Day),
        .Month  (Month),
        .Year   (Year),
        .Wday   (Wday),
        .NewDay (NewDay)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_date(input string tag, input int d, input int m, input int y, input int w);
        chk({tag, ".day"},   8'(Day),   8'(d));
        chk({tag, ".month"}, 8'(Month), 8'(m));
        chk({tag, ".year"},  8'(Year),  8'(y));
        chk({tag, ".wday"},  8'(Wday),  8'(w));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_time(input bit last);
        Hours = last ? 6'd23 : 6'd0;
        Mins  = last ? 6'd59 : 6'd0;
        Secs  = last ? 6'd59 : 6'd0;
    endtask

    task automatic rollover();
        set_time(1'b1);
        tick();
        set_time(1'b0);
    endtask

    task automatic put_fields(input int d, input int m, input int y, input int w);
        set_if.SetDay   = 5'(d);
        set_if.SetMonth = 4'(m);
        set_if.SetYear  = 7'(y);
        set_if.SetWday  = 3'(w);
    endtask

    // Full handshake; optionally fires a rollover on the CHECK edge.
    task automatic do_load(input string tag, input int d, input int m, input int y, input int w,
                           input bit roll, input bit exp_err, input bit exp_nd);
        set_if.SetReq = 1'b1;
        put_fields(d, m, y, w);
        tick();
        chk({tag, ".ack_early"}, 8'(set_if.SetAck), 8'd0);
        put_fields(0, 0, 0, 0);
        if (roll) set_time(1'b1);
        tick();
        set_time(1'b0);
        chk({tag, ".ack"},    8'(set_if.SetAck), 8'd1);
        chk({tag, ".err"},    8'(set_if.SetErr), 8'(exp_err));
        chk({tag, ".newday"}, 8'(NewDay),        8'(exp_nd));
        set_if.SetReq = 1'b0;
        tick();
        chk({tag, ".ack_end"}, 8'(set_if.SetAck), 8'd0);
    endtask

    initial begin
        RST = 1'b1;
        set_time(1'b0);
        set_if.SetReq = 1'b0;
        put_fields(0, 0, 0, 0);
        #12;
        chk_date("reset", 1, 1, 0, 6);
        chk("reset.ack",    8'(set_if.SetAck), 8'd0);
        chk("reset.err",    8'(set_if.SetErr), 8'd0);
        chk("reset.newday", 8'(NewDay),        8'd0);
        RST = 1'b0;
        tick();

        // First rollover from 2000-01-01 (Sat)
        rollover();
        chk_date("roll1", 2, 1, 0, 0);
        chk("roll1.newday", 8'(NewDay), 8'd1);
        tick();
        chk("roll1.newday_end", 8'(NewDay), 8'd0);

        // Leap February 2000
        do_load("ld_feb28_00", 28, 2, 0, 1, 1'b0, 1'b0, 1'b0);
        chk_date("ld_feb28_00", 28, 2, 0, 1);
        rollover();
        chk_date("feb29_00", 29, 2, 0, 2);
        chk("feb29_00.newday", 8'(NewDay), 8'd1);
        rollover();
        chk_date("mar1_00", 1, 3, 0, 3);

        // Non-leap February 2001
        do_load("ld_feb28_01", 28, 2, 1, 3, 1'b0, 1'b0, 1'b0);
        rollover();
        chk_date("mar1_01", 1, 3, 1, 4);

        // Century wrap 2099-12-31 -> 2000-01-01, weekday free-running
        do_load("ld_dec31_99", 31, 12, 99, 4, 1'b0, 1'b0, 1'b0);
        rollover();
        chk_date("wrap_2000", 1, 1, 0, 5);

        // Rejected loads leave the date untouched
        do_load("rej_apr31",  31, 4, 10, 0, 1'b0, 1'b1, 1'b0);
        chk_date("rej_apr31", 1, 1, 0, 5);
        do_load("rej_feb29_01", 29, 2, 1, 0, 1'b0, 1'b1, 1'b0);
        do_load("rej_month13", 1, 13, 5, 0, 1'b0, 1'b1, 1'b0);
        do_load("rej_wday7", 1, 1, 5, 7, 1'b0, 1'b1, 1'b0);
        do_load("rej_day0", 0, 1, 5, 0, 1'b0, 1'b1, 1'b0);
        chk_date("rej_all", 1, 1, 0, 5);
        do_load("ok_apr30", 30, 4, 10, 5, 1'b0, 1'b0, 1'b0);
        chk_date("ok_apr30", 30, 4, 10, 5);

        // Rollover coinciding with CHECK: valid load wins, invalid lets it through
        do_load("coll_valid", 15, 6, 20, 1, 1'b1, 1'b0, 1'b0);
        chk_date("coll_valid", 15, 6, 20, 1);
        do_load("coll_invalid", 31, 6, 20, 3, 1'b1, 1'b1, 1'b1);
        chk_date("coll_invalid", 16, 6, 20, 2);

        // Reset while in CHECK: no ack, everything back to reset values
        set_if.SetReq = 1'b1;
        put_fields(5, 5, 5, 5);
        tick();
        RST = 1'b1;
        #1;
        chk_date("rst_check", 1, 1, 0, 6);
        chk("rst_check.ack",    8'(set_if.SetAck), 8'd0);
        chk("rst_check.err",    8'(set_if.SetErr), 8'd0);
        chk("rst_check.newday", 8'(NewDay),        8'd0);
        set_if.SetReq = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        chk("rst_after.ack", 8'(set_if.SetAck), 8'd0);
        chk_date("rst_after", 1, 1, 0, 6);

        // Held SetReq: one ack only until the request is re-armed
        set_if.SetReq = 1'b1;
        put_fields(10, 10, 10, 3);
        tick();
        tick();
        chk("hold.ack", 8'(set_if.SetAck), 8'd1);
        put_fields(11, 11, 11, 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hold.noack%0d", i), 8'(set_if.SetAck), 8'd0);
        end
        chk_date("hold", 10, 10, 10, 3);
        set_if.SetReq = 1'b0;
        tick();
        set_if.SetReq = 1'b1;
        tick();
        tick();
        chk("rearm.ack", 8'(set_if.SetAck), 8'd1);
        chk("rearm.err", 8'(set_if.SetErr), 8'd0);
        chk_date("rearm", 11, 11, 11, 4);
        set_if.SetReq = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
